// File: rtl/mux_pkg.sv
// Shared definitions for the wide 2:1 selector: default datapath width
// and the matching full-width word type.
package mux_pkg;

    // Natural width of the selector datapath.
    localparam int DEFAULT_WIDTH = 100;

    // One full-width data word at the default width.
    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage : mux_pkg

// File: rtl/mux2_slice.sv
// One-bit 2:1 selector cell: y = sel ? b : a.
// The wide selector is built from WIDTH of these, so every output bit
// depends only on its own two data bits and the shared select.
module mux2_slice (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    // Pick b when sel is high, otherwise a.
    always_comb begin
        y = sel ? b : a;
    end

endmodule : mux2_slice

// File: rtl/mux2to1_wide.sv
// Wide 2:1 data selector: out = sel ? b : a over a WIDTH-bit datapath.
// REGISTER_OUT=0 gives a purely combinational path (clk/rst_n ignored);
// REGISTER_OUT=1 adds one output register cleared asynchronously by rst_n.
module mux2to1_wide
    import mux_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter bit REGISTER_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    // Bitwise selection result before the optional register.
    logic [WIDTH-1:0] mux_w;

    // One independent cell per bit keeps bit i of out tied to bit i of
    // a and b only; MSB stays MSB with no arithmetic or resizing.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
        mux2_slice u_slice (
            .a   (a[gi]),
            .b   (b[gi]),
            .sel (sel),
            .y   (mux_w[gi])
        );
    end

    if (REGISTER_OUT) begin : g_reg
        logic [WIDTH-1:0] out_d;
        logic [WIDTH-1:0] out_q;

        // Next output value is simply the current selection.
        always_comb begin
            out_d = mux_w;
        end

        // Output register; reset clears it immediately and drops any
        // selection that was about to be captured.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
            end else begin
                out_q <= out_d;
            end
        end

        assign out = out_q;
    end else begin : g_comb
        // Zero-latency path: out follows the inputs even during reset.
        assign out = mux_w;

        // Clock and reset have no role in this build; fold them into a
        // dummy net so the unused ports are intentional.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};
    end

endmodule : mux2to1_wide

// File: tb/tb_mux2to1_wide.sv
// Bench for mux2to1_wide: combinational build (WIDTH=100), registered
// build (WIDTH=100), and a WIDTH=1 combinational build for the truth table.
module tb_mux2to1_wide;

    localparam int W = 100;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sel;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    typedef struct {
        logic a;
        logic b;
        logic sel;
        logic exp;
    } bit_vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic [W-1:0] out_comb;
    logic [W-1:0] out_reg;
    logic         a1;
    logic         b1;
    logic         sel1;
    logic         out1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [W-1:0] exp_q[$];

    mux2to1_wide #(.WIDTH(W), .REGISTER_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .out(out_comb)
    );

    mux2to1_wide #(.WIDTH(W), .REGISTER_OUT(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .out(out_reg)
    );

    mux2to1_wide #(.WIDTH(1), .REGISTER_OUT(1'b0)) u_bit (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .out(out1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %s: out=%h", name, got);
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic rand_drive();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        a = r[W-1:0];
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = r[W-1:0];
        sel = 1'($urandom_range(0, 1));
    endtask

    initial begin
        vec_t         vecs[6];
        bit_vec_t     bvecs[8];
        logic [W-1:0] ones;
        logic [W-1:0] cval;
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;

        ones = '1;
        cval = 100'h1_2345_6789_ABCD_EF01_2345_6789;

        vecs[0] = '{ones,   '0,   1'b0, ones,   "ones_a_sel0"};
        vecs[1] = '{ones,   '0,   1'b1, '0,     "ones_a_sel1"};
        vecs[2] = '{'0,     ones, 1'b1, ones,   "ones_b_sel1"};
        vecs[3] = '{'0,     ones, 1'b0, '0,     "ones_b_sel0"};
        vecs[4] = '{cval,   cval, 1'b0, cval,   "a_eq_b_sel0"};
        vecs[5] = '{cval,   cval, 1'b1, cval,   "a_eq_b_sel1"};

        // {a,b,sel} -> expected mux output, written out by hand
        bvecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        bvecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        bvecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bvecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
        bvecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bvecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bvecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
        bvecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        // Power-up in reset
        rst_n = 1'b0;
        a = '0; b = '0; sel = 1'b0;
        a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
        #2;
        check("reset_reg_out", out_reg, '0);
        a = 100'h123;
        #1;
        check("reset_comb_follows", out_comb, 100'h123);
        @(posedge clk); #1;
        check("reset_reg_held", out_reg, '0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        // Test 1: sel toggled on posedge, comb out follows immediately
        a = 100'hDEADBEEF;
        b = 100'h5EAF00D;
        sel = 1'b0;
        #1;
        check("t1_initial", out_comb, 100'hDEADBEEF);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            sel = ~sel;
            #1;
            check($sformatf("t1_toggle%0d", i), out_comb,
                  sel ? 100'h5EAF00D : 100'hDEADBEEF);
        end

        // Test 2: random updates on both edges; registered build scored
        // through a queue of expected values pushed at drive time.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #2;
            rand_drive();
            exp_v = sel ? b : a;
            exp_q.push_back(exp_v);
            #1;
            check($sformatf("t2_comb_neg%0d", i), out_comb, exp_v);
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL t2_reg%0d: scoreboard empty", i);
            end else begin
                check($sformatf("t2_reg%0d", i), out_reg, exp_q.pop_front());
            end
            #1;
            rand_drive();
            exp_v = sel ? b : a;
            #1;
            check($sformatf("t2_comb_pos%0d", i), out_comb, exp_v);
        end

        // Tests 3/4: boundary vectors from the table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            a = vecs[i].a; b = vecs[i].b; sel = vecs[i].sel;
            #1;
            check({"tab_", vecs[i].name}, out_comb, vecs[i].exp);
        end

        // Test 5: reset pulse with sel=1, b=0xFF
        @(negedge clk); #2;
        a = '0; b = 100'hFF; sel = 1'b1;
        @(posedge clk); #1;
        check("t5_reg_loaded", out_reg, 100'hFF);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t5_reg_async_clear", out_reg, '0);
        check("t5_comb_in_reset", out_comb, 100'hFF);
        @(posedge clk); #1;
        check("t5_reg_clear_on_edge", out_reg, '0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("t5_reg_wait_edge", out_reg, '0);
        check("t5_comb_after", out_comb, 100'hFF);
        @(posedge clk); #1;
        check("t5_reg_reload", out_reg, 100'hFF);

        // Test 6: WIDTH=1 truth table
        for (int i = 0; i < 8; i++) begin
            a1 = bvecs[i].a; b1 = bvecs[i].b; sel1 = bvecs[i].sel;
            #1;
            got_v = '0;
            got_v[0] = out1;
            exp_v = '0;
            exp_v[0] = bvecs[i].exp;
            check($sformatf("t6_abs_%0d%0d%0d", a1, b1, sel1), got_v, exp_v);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_mux2to1_wide
